// File: rtl/botoes_condicionador_if.sv
// Button-conditioner bus: raw pins in, one-hot vector plus status out.
// master = pin/datapath side, slave = the conditioner itself.
interface botoes_condicionador_if;
  logic [3:0] botoes_raw;
  logic [3:0] botoes;
  logic       multiplo;
  logic [1:0] db_estado;

  modport master (
    output botoes_raw,
    input  botoes,
    input  multiplo,
    input  db_estado
  );

  modport slave (
    input  botoes_raw,
    output botoes,
    output multiplo,
    output db_estado
  );
endinterface

// File: rtl/botoes_condicionador.sv
// Synchronise, debounce and qualify four push-buttons into a clean one-hot vector.
// Optional macro BOTOES_PRIORIDADE_EN: chords resolve to the lowest-index button instead of being rejected.
//
// state    | meaning
// OCIOSO   | no button held, botoes = 0
// UNICO    | exactly one button accepted, botoes = latched code
// MULTIPLO | chord rejected, botoes = 0 until every button is released
module botoes_condicionador #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int CNT_W           = 7
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  botoes_condicionador_if.slave bus
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    UNICO    = 2'd1,
    MULTIPLO = 2'd2
  } estado_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_deb;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       r_cod;
  logic [3:0]       r_botoes;
  logic             r_multiplo;
  estado_t          r_estado;

  logic             w_onehot;
  logic             w_vazio;

  assign w_vazio  = (r_deb == 4'd0);
  assign w_onehot = !w_vazio && ((r_deb & (r_deb - 4'd1)) == 4'd0);

`ifdef BOTOES_PRIORIDADE_EN
  logic [3:0] w_menor;
  assign w_menor = r_deb & (~r_deb + 4'd1);
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
    end else begin
      r_sync1 <= bus.botoes_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A counter only advances while the synchronised level disagrees, so any bounce restarts it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_deb <= 4'd0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == LP_CNT_MAX) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_estado   <= OCIOSO;
      r_cod      <= 4'd0;
      r_botoes   <= 4'd0;
      r_multiplo <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (w_onehot) begin
            r_cod    <= r_deb;
            r_botoes <= r_deb;
            r_estado <= UNICO;
          end else if (!w_vazio) begin
`ifdef BOTOES_PRIORIDADE_EN
            r_cod    <= w_menor;
            r_botoes <= w_menor;
            r_estado <= UNICO;
`else
            r_multiplo <= 1'b1;
            r_estado   <= MULTIPLO;
`endif
          end
        end
        UNICO: begin
          if (w_vazio) begin
            r_botoes <= 4'd0;
            r_estado <= OCIOSO;
`ifdef BOTOES_PRIORIDADE_EN
          end else if ((r_deb & r_cod) == 4'd0) begin
`else
          end else if (r_deb != r_cod) begin
`endif
            // Never hand the datapath a direct one-hot to one-hot swap.
            r_botoes   <= 4'd0;
            r_multiplo <= 1'b1;
            r_estado   <= MULTIPLO;
          end
        end
        MULTIPLO: begin
          if (w_vazio) begin
            r_multiplo <= 1'b0;
            r_estado   <= OCIOSO;
          end
        end
        default: begin
          r_botoes   <= 4'd0;
          r_multiplo <= 1'b0;
          r_estado   <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.botoes    = r_botoes;
  assign bus.multiplo  = r_multiplo;
  assign bus.db_estado = r_estado;

endmodule

// File: tb/tb_botoes_condicionador.sv
// Directed bench for botoes_condicionador with a per-cycle reference model.
// Expectations follow BOTOES_PRIORIDADE_EN when it is defined.
module tb_botoes_condicionador;

  localparam int D = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_rise;
  int   r0;

  botoes_condicionador_if u_if ();

  botoes_condicionador #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) u_dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a level must be seen D edges in a row before it is accepted.
  logic [3:0]   m_s1, m_s2, m_deb, m_cod;
  logic [D-1:0] m_hist [4];
  logic         m_reject;

  initial begin
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_cod = '0; m_reject = 1'b0;
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_cod = '0; m_reject = 1'b0;
      for (int i = 0; i < 4; i++) m_hist[i] = '0;
    end else begin
      if (m_reject) begin
        if (m_deb == 4'd0) m_reject = 1'b0;
      end else if (m_cod != 4'd0) begin
        if (m_deb == 4'd0) m_cod = 4'd0;
`ifdef BOTOES_PRIORIDADE_EN
        else if ((m_deb & m_cod) == 4'd0) begin
`else
        else if (m_deb != m_cod) begin
`endif
          m_cod = 4'd0;
          m_reject = 1'b1;
        end
      end else if (m_deb != 4'd0) begin
        if ($countones(m_deb) == 1) m_cod = m_deb;
        else begin
`ifdef BOTOES_PRIORIDADE_EN
          for (int k = 3; k >= 0; k--) if (m_deb[k]) m_cod = 4'(1 << k);
`else
          m_reject = 1'b1;
`endif
        end
      end
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = {m_hist[i][D-2:0], m_s2[i]};
        if (m_hist[i] == {D{~m_deb[i]}}) m_deb[i] = ~m_deb[i];
      end
      m_s2 = m_s1;
      m_s1 = u_if.botoes_raw;
    end
  end

  always @(negedge clk) begin
    chk("mdl_botoes", 8'(u_if.botoes), 8'(m_reject ? 4'd0 : m_cod));
    chk("mdl_multiplo", 8'(u_if.multiplo), 8'(m_reject));
    chk("mdl_estado", 8'(u_if.db_estado), m_reject ? 8'd2 : (m_cod != 4'd0 ? 8'd1 : 8'd0));
  end

  logic prev_any;
  initial begin
    n_rise = 0;
    prev_any = 1'b0;
  end
  always @(negedge clk) begin
    if (!prev_any && (|u_if.botoes)) n_rise++;
    prev_any = |u_if.botoes;
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    u_if.botoes_raw = 4'b0000;
    tick(3);
    u_if.botoes_raw = 4'b0100;
    tick(3);
    chk("rst_botoes", 8'(u_if.botoes), 8'h0);
    chk("rst_multiplo", 8'(u_if.multiplo), 8'h0);
    chk("rst_estado", 8'(u_if.db_estado), 8'h0);
    rst = 1'b0;
    tick(6);
    chk("rst_lat6", 8'(u_if.botoes), 8'h0);
    tick(1);
    chk("rst_lat7", 8'(u_if.botoes), 8'h4);
    chk("rst_estado_unico", 8'(u_if.db_estado), 8'h1);
    u_if.botoes_raw = 4'b0000;
    tick(7);
    chk("rst_release", 8'(u_if.botoes), 8'h0);
    tick(5);

    r0 = n_rise;
    u_if.botoes_raw = 4'b0010;
    tick(6);
    chk("press_lat6", 8'(u_if.botoes), 8'h0);
    tick(1);
    chk("press_lat7", 8'(u_if.botoes), 8'h2);
    tick(13);
    u_if.botoes_raw = 4'b0000;
    tick(6);
    chk("release_lat6", 8'(u_if.botoes), 8'h2);
    tick(1);
    chk("release_lat7", 8'(u_if.botoes), 8'h0);
    tick(3);
    chk("press_one_edge", 8'(n_rise - r0), 8'd1);

    r0 = n_rise;
    for (int j = 0; j < 4; j++) begin
      u_if.botoes_raw = (j % 2 == 0) ? 4'b0001 : 4'b0000;
      tick(1);
      chk("bounce_quiet", 8'(u_if.botoes), 8'h0);
    end
    u_if.botoes_raw = 4'b0001;
    tick(6);
    chk("bounce_lat6", 8'(u_if.botoes), 8'h0);
    chk("bounce_no_edge", 8'(n_rise - r0), 8'd0);
    tick(1);
    chk("bounce_lat7", 8'(u_if.botoes), 8'h1);
    u_if.botoes_raw = 4'b0000;
    tick(10);

    r0 = n_rise;
    u_if.botoes_raw = 4'b1000;
    tick(3);
    u_if.botoes_raw = 4'b0000;
    tick(15);
    chk("short_pulse_edges", 8'(n_rise - r0), 8'd0);
    chk("short_pulse_botoes", 8'(u_if.botoes), 8'h0);

    u_if.botoes_raw = 4'b0001;
    tick(10);
    chk("chord_first", 8'(u_if.botoes), 8'h1);
    u_if.botoes_raw = 4'b0101;
    tick(7);
`ifdef BOTOES_PRIORIDADE_EN
    chk("chord_add_botoes", 8'(u_if.botoes), 8'h1);
    chk("chord_add_multiplo", 8'(u_if.multiplo), 8'h0);
`else
    chk("chord_add_botoes", 8'(u_if.botoes), 8'h0);
    chk("chord_add_multiplo", 8'(u_if.multiplo), 8'h1);
    chk("chord_add_estado", 8'(u_if.db_estado), 8'h2);
`endif
    u_if.botoes_raw = 4'b0100;
    tick(10);
    chk("chord_rel0_botoes", 8'(u_if.botoes), 8'h0);
    chk("chord_rel0_multiplo", 8'(u_if.multiplo), 8'h1);
    u_if.botoes_raw = 4'b0000;
    tick(6);
    chk("chord_rel2_lat6", 8'(u_if.multiplo), 8'h1);
    tick(1);
    chk("chord_rel2_lat7", 8'(u_if.multiplo), 8'h0);
    chk("chord_idle_estado", 8'(u_if.db_estado), 8'h0);
    tick(5);

    u_if.botoes_raw = 4'b1010;
    tick(7);
`ifdef BOTOES_PRIORIDADE_EN
    chk("simul_botoes", 8'(u_if.botoes), 8'h2);
    chk("simul_multiplo", 8'(u_if.multiplo), 8'h0);
`else
    chk("simul_botoes", 8'(u_if.botoes), 8'h0);
    chk("simul_multiplo", 8'(u_if.multiplo), 8'h1);
`endif
    u_if.botoes_raw = 4'b1000;
    tick(7);
    chk("simul_rel1_botoes", 8'(u_if.botoes), 8'h0);
    chk("simul_rel1_multiplo", 8'(u_if.multiplo), 8'h1);
    u_if.botoes_raw = 4'b0000;
    tick(7);
    chk("simul_idle", 8'(u_if.multiplo), 8'h0);
    tick(3);

    u_if.botoes_raw = 4'b0010;
    tick(7);
    chk("swap_first", 8'(u_if.botoes), 8'h2);
    u_if.botoes_raw = 4'b0100;
    tick(7);
    chk("swap_botoes", 8'(u_if.botoes), 8'h0);
    chk("swap_multiplo", 8'(u_if.multiplo), 8'h1);
    chk("swap_estado", 8'(u_if.db_estado), 8'h2);
    u_if.botoes_raw = 4'b0000;
    tick(7);
    chk("swap_idle", 8'(u_if.db_estado), 8'h0);
    tick(3);

    u_if.botoes_raw = 4'b0001;
    tick(4);
    rst = 1'b1;
    tick(2);
    chk("midreset_botoes", 8'(u_if.botoes), 8'h0);
    rst = 1'b0;
    tick(6);
    chk("midreset_lat6", 8'(u_if.botoes), 8'h0);
    tick(1);
    chk("midreset_lat7", 8'(u_if.botoes), 8'h1);
    rst = 1'b1;
    tick(1);
    chk("pressreset_botoes", 8'(u_if.botoes), 8'h0);
    chk("pressreset_estado", 8'(u_if.db_estado), 8'h0);
    u_if.botoes_raw = 4'b0000;
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("final_idle", 8'(u_if.botoes), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/botoes_condicionador.md
Name: botoes_condicionador

Overview:
- Input-conditioning stage directly upstream of the game datapath's `botoes[3:0]` input.
- Takes the four raw, asynchronous, bouncy push-buttons from the FPGA pins. Synchronises and debounces each one, then qualifies the pattern through a small FSM.
- Presents a clean, glitch-free, one-hot `botoes` vector. The datapath's OR/edge-detector then sees exactly one rising edge per physical press.
- Illegal simultaneous presses are rejected and flagged until all buttons are released.

Parameters:
- DEBOUNCE_CYCLES, 100: consecutive stable cycles required before a debounced bit changes (20 ms at 5 kHz).
- CNT_W, 7: width of each per-button debounce counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- botoes_raw  in  4  raw button pins, asynchronous, active-high.
- botoes  out  4  conditioned one-hot button vector to the datapath; 4'b0000 when idle or invalid.
- multiplo  out  1  high while in the multiple-press rejection state.
- db_estado  out  2  FSM state encoding for debug (0 OCIOSO, 1 UNICO, 2 MULTIPLO).

Behaviour:
- Reset: all synchroniser flops, debounced bits, counters and latched code go to 0; FSM goes to OCIOSO; `botoes`=0, `multiplo`=0, `db_estado`=0. Reset applies at any time, including mid-debounce or mid-press.
- Synchroniser: two flops per bit, giving `s_sync[3:0]`.
- Debounce, per bit i (independent):
  - If `s_sync[i]` differs from `s_deb[i]`, `cnt[i]` increments.
  - When `cnt[i]` = DEBOUNCE_CYCLES-1 and the bit still differs, `s_deb[i]` takes `s_sync[i]` and `cnt[i]` clears.
  - Any cycle with `s_sync[i]` equal to `s_deb[i]` clears `cnt[i]`, so a bounce restarts the count.
  - Counters never wrap.
- Latency:
  - Raw edge held stable to `s_deb` change: DEBOUNCE_CYCLES+2 clock edges.
  - FSM adds 1 cycle (registered outputs).
  - Total raw-to-`botoes`: DEBOUNCE_CYCLES+3 edges.
  - Identical latency on release.
- FSM, evaluated on `s_deb`; outputs registered on state entry:
  - OCIOSO: `botoes`=0, `multiplo`=0.
    - `s_deb` one-hot: latch it as `cod`, go to UNICO.
    - Two or more bits set: go to MULTIPLO.
    - Otherwise stay.
  - UNICO: `botoes`=`cod`, `multiplo`=0.
    - `s_deb`=0: go to OCIOSO.
    - `s_deb`≠`cod` (extra button, or a swap without passing through zero): go to MULTIPLO.
    - Otherwise stay.
  - MULTIPLO: `botoes`=0, `multiplo`=1.
    - Stay until `s_deb`=0, then go to OCIOSO.
    - Nothing is emitted until a full release, so the datapath never sees a second edge from one chord.
- Simultaneous events:
  - Two bits debouncing valid on the same cycle in OCIOSO are treated as multiple.
  - A release and a new press on the same cycle in UNICO give `s_deb`≠`cod` and ≠0, so the FSM goes to MULTIPLO.
- `botoes` only changes 0 to one-hot or one-hot to 0. A direct one-hot-to-different-one-hot transition is forbidden.

Optional Feature:
- Macro: BOTOES_PRIORIDADE_EN.
- Defined:
  - In OCIOSO, two or more bits set latches the lowest-index set bit as `cod` and goes to UNICO.
  - In UNICO, extra bits are ignored while `s_deb[cod]` stays 1.
  - If `cod` is released while others remain, the FSM goes to MULTIPLO and waits for all released.
  - MULTIPLO is then unreachable from OCIOSO.
- Undefined: behaviour exactly as specified above, with chords rejected.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset with `botoes_raw`=4'b0100 held -> outputs 0 during reset; `botoes`=4'b0100 exactly 7 edges after reset deasserts; `db_estado`=1.
- Clean press of bit 1 held 20 cycles, then release -> `botoes`=4'b0010 from edge 7 after press; back to 0 at edge 7 after release; exactly one rising edge of `|botoes`.
- Bounce: bit 0 toggled 1,0,1,0 each cycle, then held 1 -> `botoes` stays 0 during the toggling; becomes 4'b0001 7 edges after the final stable 1.
- Pulse shorter than debounce: bit 3 high for 3 cycles -> `botoes` never leaves 0.
- Chord: bit 0 pressed, bit 2 added 10 cycles later -> `botoes` 0001, then 0000 with `multiplo`=1; release bit 0 only -> still MULTIPLO; release bit 2 -> OCIOSO, `multiplo`=0.
- With BOTOES_PRIORIDADE_EN, bits 3 and 1 rising on the same cycle -> `botoes`=4'b0010, `multiplo` stays 0; release bit 1 while bit 3 held -> `multiplo`=1.
